// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Owns the fetch PC and runs a single-outstanding request/response handshake
// with instruction memory. Branch and exception redirects move the PC, raise
// a one-cycle flush, and cause any response belonging to the old path to be
// discarded. A fetched instruction is held until the instruction FIFO
// accepts it.
//
// Ports:
//   CLK, RST                       clock, synchronous active-high reset
//   excp_valid / excp_pc           exception redirect (wins over branch)
//   branch_valid / branch_pc       branch/jalr redirect
//   imem_req_valid/_ready/_addr    request channel to instruction memory
//   imem_rsp_valid / imem_rsp_data one-cycle response from instruction memory
//   fetch_valid/_instr/_pc         registered instruction toward decode
//   instrFifo_full                 downstream back-pressure
//   flush                          one-cycle pulse the cycle after a redirect
module fetch_sequencer #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        excp_valid,
  input  logic [63:0] excp_pc,
  input  logic        branch_valid,
  input  logic [63:0] branch_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  output logic [63:0] fetch_pc,
  input  logic        instrFifo_full,
  output logic        flush
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        fetchValid_q, fetchValid_d;
  logic [31:0] fetchInstr_q, fetchInstr_d;
  logic [63:0] fetchPc_q, fetchPc_d;
  logic        flush_q, flush_d;

  logic        redir;
  logic [63:0] redirTarget;

  assign redir       = excp_valid | branch_valid;
  assign redirTarget = excp_valid ? excp_pc : branch_pc;

  // State and output registers; reset is sampled on the clock edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      fetchValid_q <= 1'b0;
      fetchInstr_q <= 32'h0;
      fetchPc_q    <= 64'h0;
      flush_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetchValid_q <= fetchValid_d;
      fetchInstr_q <= fetchInstr_d;
      fetchPc_q    <= fetchPc_d;
      flush_q      <= flush_d;
    end
  end

  // Next-state logic: the normal fetch flow first, then a redirect overrides
  // both the PC and the transition so that anything fetched on the old path
  // is either dropped immediately or drained when its response arrives.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetchValid_d = fetchValid_q;
    fetchInstr_d = fetchInstr_q;
    fetchPc_d    = fetchPc_q;
    flush_d      = redir;

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          fetchValid_d = 1'b1;
          fetchInstr_d = imem_rsp_data;
          fetchPc_d    = pc_q;
          pc_d         = pc_q + 64'd4;
          state_d      = S_HOLD;
        end
      end
      S_HOLD: begin
        if (fetchValid_q && !instrFifo_full) begin
          fetchValid_d = 1'b0;
          state_d      = S_REQ;
        end
      end
      S_DRAIN: begin
        if (imem_rsp_valid) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase

    if (redir) begin
      pc_d         = redirTarget;
      fetchValid_d = 1'b0;
      fetchInstr_d = fetchInstr_q;
      fetchPc_d    = fetchPc_q;
      case (state_q)
        S_REQ:   state_d = imem_req_ready ? S_DRAIN : S_REQ;
        S_WAIT:  state_d = imem_rsp_valid ? S_REQ : S_DRAIN;
        S_DRAIN: state_d = imem_rsp_valid ? S_REQ : S_DRAIN;
        default: state_d = S_REQ;
      endcase
    end
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign fetch_valid    = fetchValid_q;
  assign fetch_instr    = fetchInstr_q;
  assign fetch_pc       = fetchPc_q;
  assign flush          = flush_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
// Directed bench for fetch_sequencer. The memory and FIFO are driven by hand
// from each scenario task; every expected value is a hand-computed constant.
module tb_fetch_sequencer;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic        CLK;
  logic        RST;
  logic        excp_valid;
  logic [63:0] excp_pc;
  logic        branch_valid;
  logic [63:0] branch_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [63:0] fetch_pc;
  logic        instrFifo_full;
  logic        flush;

  int passCount;
  int checkCount;

  fetch_sequencer #(.RESET_PC(RESET_PC)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .excp_valid     (excp_valid),
    .excp_pc        (excp_pc),
    .branch_valid   (branch_valid),
    .branch_pc      (branch_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .fetch_valid    (fetch_valid),
    .fetch_instr    (fetch_instr),
    .fetch_pc       (fetch_pc),
    .instrFifo_full (instrFifo_full),
    .flush          (flush)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Holds reset for two cycles, then steps into the first REQ cycle.
  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    checkCount++;
    if (imem_req_valid !== 1'b0) $display("[TB] FAIL rst_reqValid got %0b exp 0", imem_req_valid);
    else passCount++;
    checkCount++;
    if (fetch_valid !== 1'b0) $display("[TB] FAIL rst_fetchValid got %0b exp 0", fetch_valid);
    else passCount++;
    checkCount++;
    if (flush !== 1'b0) $display("[TB] FAIL rst_flush got %0b exp 0", flush);
    else passCount++;
    checkCount++;
    if (fetch_instr !== 32'h0 || fetch_pc !== 64'h0)
      $display("[TB] FAIL rst_outReg got %h/%h exp 0/0", fetch_instr, fetch_pc);
    else passCount++;
    checkCount++;
    if (imem_req_addr !== RESET_PC) $display("[TB] FAIL rst_addr got %h exp %h", imem_req_addr, RESET_PC);
    else passCount++;
    RST = 1'b0;
    tick();
    checkCount++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC)
      $display("[TB] FAIL rst_firstReq got %0b/%h exp 1/%h", imem_req_valid, imem_req_addr, RESET_PC);
    else passCount++;
  endtask

  // Three back-to-back fetches with zero-wait memory: REQ, WAIT, HOLD pitch.
  task automatic test_sequential();
    logic [63:0] expAddr;
    logic [31:0] word;
    for (int i = 0; i < 3; i++) begin
      expAddr = RESET_PC + 64'(4 * i);
      word    = 32'hA000_0000 + 32'(i);
      checkCount++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== expAddr)
        $display("[TB] FAIL seq_req%0d got %0b/%h exp 1/%h", i, imem_req_valid, imem_req_addr, expAddr);
      else passCount++;
      tick();
      checkCount++;
      if (imem_req_valid !== 1'b0 || fetch_valid !== 1'b0)
        $display("[TB] FAIL seq_wait%0d got req %0b fv %0b exp 0/0", i, imem_req_valid, fetch_valid);
      else passCount++;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word;
      tick();
      imem_rsp_valid = 1'b0;
      checkCount++;
      if (fetch_valid !== 1'b1 || fetch_instr !== word || fetch_pc !== expAddr)
        $display("[TB] FAIL seq_hold%0d got %0b/%h/%h exp 1/%h/%h", i, fetch_valid, fetch_instr, fetch_pc, word, expAddr);
      else passCount++;
      tick();
    end
  endtask

  // Back-pressure in HOLD: outputs frozen, no request until consumption.
  task automatic test_fifo_full();
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hB0B0_0001;
    tick();
    imem_rsp_valid = 1'b0;
    instrFifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checkCount++;
      if (fetch_valid !== 1'b1 || fetch_instr !== 32'hB0B0_0001 || fetch_pc !== 64'h8000_000C || imem_req_valid !== 1'b0)
        $display("[TB] FAIL full_stall%0d got %0b/%h/%h req %0b exp 1/b0b00001/800000000c req 0",
                 k, fetch_valid, fetch_instr, fetch_pc, imem_req_valid);
      else passCount++;
    end
    instrFifo_full = 1'b0;
    tick();
    checkCount++;
    if (fetch_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0010)
      $display("[TB] FAIL full_release got fv %0b req %0b addr %h exp 0/1/80000010", fetch_valid, imem_req_valid, imem_req_addr);
    else passCount++;
  endtask

  // Branch while waiting; the late response must be drained, never shown.
  task automatic test_branch_wait();
    tick();
    branch_valid = 1'b1;
    branch_pc    = 64'h1000;
    tick();
    branch_valid = 1'b0;
    checkCount++;
    if (flush !== 1'b1 || imem_req_valid !== 1'b0 || fetch_valid !== 1'b0)
      $display("[TB] FAIL brw_flush got flush %0b req %0b fv %0b exp 1/0/0", flush, imem_req_valid, fetch_valid);
    else passCount++;
    tick();
    checkCount++;
    if (flush !== 1'b0 || imem_req_valid !== 1'b0)
      $display("[TB] FAIL brw_drain got flush %0b req %0b exp 0/0", flush, imem_req_valid);
    else passCount++;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    checkCount++;
    if (fetch_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h1000)
      $display("[TB] FAIL brw_newReq got fv %0b req %0b addr %h exp 0/1/1000", fetch_valid, imem_req_valid, imem_req_addr);
    else passCount++;
  endtask

  // Exception and branch together in HOLD: exception target wins, instr dropped.
  task automatic test_excp_priority();
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1234_5678;
    tick();
    imem_rsp_valid = 1'b0;
    checkCount++;
    if (fetch_valid !== 1'b1 || fetch_pc !== 64'h1000)
      $display("[TB] FAIL exc_hold got %0b/%h exp 1/1000", fetch_valid, fetch_pc);
    else passCount++;
    excp_valid   = 1'b1;
    excp_pc      = 64'h200;
    branch_valid = 1'b1;
    branch_pc    = 64'h300;
    tick();
    excp_valid   = 1'b0;
    branch_valid = 1'b0;
    checkCount++;
    if (flush !== 1'b1 || fetch_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h200)
      $display("[TB] FAIL exc_redirect got flush %0b fv %0b req %0b addr %h exp 1/0/1/200",
               flush, fetch_valid, imem_req_valid, imem_req_addr);
    else passCount++;
  endtask

  // Redirect coinciding with the request handshake drains the stale response.
  task automatic test_redirect_handshake();
    branch_valid = 1'b1;
    branch_pc    = 64'h400;
    tick();
    branch_valid = 1'b0;
    checkCount++;
    if (flush !== 1'b1 || imem_req_valid !== 1'b0)
      $display("[TB] FAIL rhs_drain got flush %0b req %0b exp 1/0", flush, imem_req_valid);
    else passCount++;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h5555_AAAA;
    tick();
    imem_rsp_valid = 1'b0;
    checkCount++;
    if (fetch_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h400 || flush !== 1'b0)
      $display("[TB] FAIL rhs_newReq got fv %0b req %0b addr %h flush %0b exp 0/1/400/0",
               fetch_valid, imem_req_valid, imem_req_addr, flush);
    else passCount++;
  endtask

  // Consecutive redirects while the request is stalled: flush stays high.
  task automatic test_back_to_back();
    imem_req_ready = 1'b0;
    branch_valid   = 1'b1;
    branch_pc      = 64'h500;
    tick();
    checkCount++;
    if (flush !== 1'b1 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h500)
      $display("[TB] FAIL b2b_first got flush %0b req %0b addr %h exp 1/1/500", flush, imem_req_valid, imem_req_addr);
    else passCount++;
    branch_pc = 64'h600;
    tick();
    branch_valid = 1'b0;
    checkCount++;
    if (flush !== 1'b1 || imem_req_addr !== 64'h600)
      $display("[TB] FAIL b2b_second got flush %0b addr %h exp 1/600", flush, imem_req_addr);
    else passCount++;
    tick();
    checkCount++;
    if (flush !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h600)
      $display("[TB] FAIL b2b_settle got flush %0b req %0b addr %h exp 0/1/600", flush, imem_req_valid, imem_req_addr);
    else passCount++;
  endtask

  // Fetch at the top of the address space; the following PC wraps to zero.
  task automatic test_wrap();
    branch_valid = 1'b1;
    branch_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    branch_valid   = 1'b0;
    imem_req_ready = 1'b1;
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hCAFE_F00D;
    tick();
    imem_rsp_valid = 1'b0;
    checkCount++;
    if (fetch_valid !== 1'b1 || fetch_pc !== 64'hFFFF_FFFF_FFFF_FFFC || fetch_instr !== 32'hCAFE_F00D)
      $display("[TB] FAIL wrap_hold got %0b/%h/%h exp 1/fffffffffffffffc/cafef00d", fetch_valid, fetch_pc, fetch_instr);
    else passCount++;
    tick();
    checkCount++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0)
      $display("[TB] FAIL wrap_nextReq got %0b/%h exp 1/0", imem_req_valid, imem_req_addr);
    else passCount++;
  endtask

  // Reset during WAIT with the response arriving afterwards.
  task automatic test_reset_in_wait();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checkCount++;
    if (imem_req_valid !== 1'b0 || fetch_valid !== 1'b0 || flush !== 1'b0 || fetch_pc !== 64'h0 || fetch_instr !== 32'h0)
      $display("[TB] FAIL rwait_reset got req %0b fv %0b flush %0b pc %h instr %h exp 0/0/0/0/0",
               imem_req_valid, fetch_valid, flush, fetch_pc, fetch_instr);
    else passCount++;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0BAD_0BAD;
    tick();
    imem_rsp_valid = 1'b0;
    checkCount++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC || fetch_valid !== 1'b0)
      $display("[TB] FAIL rwait_firstReq got req %0b addr %h fv %0b exp 1/%h/0", imem_req_valid, imem_req_addr, fetch_valid, RESET_PC);
    else passCount++;
    tick();
    checkCount++;
    if (fetch_valid !== 1'b0 || imem_req_valid !== 1'b0)
      $display("[TB] FAIL rwait_noStale got fv %0b req %0b exp 0/0", fetch_valid, imem_req_valid);
    else passCount++;
  endtask

  // Guard against a hung simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout exp completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    passCount      = 0;
    checkCount     = 0;
    RST            = 1'b1;
    excp_valid     = 1'b0;
    excp_pc        = 64'h0;
    branch_valid   = 1'b0;
    branch_pc      = 64'h0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    instrFifo_full = 1'b0;
    #1;
    test_reset();
    test_sequential();
    test_fifo_full();
    test_branch_wait();
    test_excp_priority();
    test_redirect_handshake();
    test_back_to_back();
    test_wrap();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
